// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants: opcodes, funct7 values and ALU select codes.
// No logic, no latency.
// The ALU decodes the same ALUSEL_* values, so this encoding is fixed.
package riscv_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   localparam logic [3:0] ALUSEL_SUB   = 4'h0;
   localparam logic [3:0] ALUSEL_ADD   = 4'h1;
   localparam logic [3:0] ALUSEL_SLL   = 4'h2;
   localparam logic [3:0] ALUSEL_SLT   = 4'h3;
   localparam logic [3:0] ALUSEL_SLTU  = 4'h4;
   localparam logic [3:0] ALUSEL_XOR   = 4'h5;
   localparam logic [3:0] ALUSEL_SRA   = 4'h6;
   localparam logic [3:0] ALUSEL_SRL   = 4'h7;
   localparam logic [3:0] ALUSEL_OR    = 4'h8;
   localparam logic [3:0] ALUSEL_AND   = 4'h9;
   localparam logic [3:0] ALUSEL_PASSB = 4'hF;

   // funct3 -> ALU select; alt selects SUB/SRA and is only consulted for 000/101.
   function automatic logic [3:0] funct3_sel(input logic [2:0] f3, input logic alt);
      logic [3:0] sel;
      case (f3)
         3'b000:  sel = alt ? ALUSEL_SUB : ALUSEL_ADD;
         3'b001:  sel = ALUSEL_SLL;
         3'b010:  sel = ALUSEL_SLT;
         3'b011:  sel = ALUSEL_SLTU;
         3'b100:  sel = ALUSEL_XOR;
         3'b101:  sel = alt ? ALUSEL_SRA : ALUSEL_SRL;
         3'b110:  sel = ALUSEL_OR;
         default: sel = ALUSEL_AND;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: extracts the I/S/B/U/J immediates and shift amount.
// Purely combinational, zero latency.
// No flow control; outputs follow inst directly.
module imm_gen #(
   parameter int XLEN = 32
) (
   input  logic [31:0]     inst,
   output logic [XLEN-1:0] imm_i,
   output logic [XLEN-1:0] imm_s,
   output logic [XLEN-1:0] imm_b,
   output logic [XLEN-1:0] imm_u,
   output logic [XLEN-1:0] imm_j,
   output logic [XLEN-1:0] shamt
);

   // Signed size-casts sign-extend each field to XLEN; shamt zero-extends.
   assign imm_i = XLEN'($signed(inst[31:20]));
   assign imm_s = XLEN'($signed({inst[31:25], inst[11:7]}));
   assign imm_b = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
   assign imm_u = XLEN'($signed({inst[31:12], 12'b0}));
   assign imm_j = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
   assign shamt = XLEN'(inst[24:20]);

endmodule

// File: rtl/id_ex_decode.sv
// ID/EX decode stage: RV32I instruction -> ALU select, operands, rd, wen (ID_ILLEGAL_TRAP_EN: trap illegal ops).
// Latency 1 cycle; registered outputs, no id_* -> ex_* combinational path.
// stall holds the register and drops id_ready; flush/reset load a bubble.
module id_ex_decode
   import riscv_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            id_valid,
   output logic            id_ready,
   input  logic [31:0]     id_inst,
   input  logic [XLEN-1:0] id_pc,
   input  logic [XLEN-1:0] id_rs1_data,
   input  logic [XLEN-1:0] id_rs2_data,
   input  logic            stall,
   input  logic            flush,
   output logic            ex_valid,
   output logic [3:0]      ex_alusel,
   output logic [XLEN-1:0] ex_alu1,
   output logic [XLEN-1:0] ex_alu2,
   output logic [4:0]      ex_rd,
   output logic            ex_reg_wen,
   output logic [XLEN-1:0] ex_pc,
   output logic            ex_illegal
);

   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt;
   logic [6:0]      opcode;
   logic [2:0]      f3;
   logic [6:0]      f7;
   logic [4:0]      rd;

   logic [3:0]      dec_sel;
   logic [XLEN-1:0] dec_a, dec_b;
   logic            dec_wen, dec_legal;

   logic            ld_valid, ld_wen, ld_ill;
   logic [3:0]      ld_sel;
   logic [XLEN-1:0] ld_a, ld_b, ld_pc;
   logic [4:0]      ld_rd;

   assign opcode   = id_inst[6:0];
   assign f3       = id_inst[14:12];
   assign f7       = id_inst[31:25];
   assign rd       = id_inst[11:7];
   assign id_ready = ~stall;

   imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .inst  (id_inst),
      .imm_i (imm_i),
      .imm_s (imm_s),
      .imm_b (imm_b),
      .imm_u (imm_u),
      .imm_j (imm_j),
      .shamt (shamt)
   );

   // Opcode decode into ALU select, operands and write-enable.
   always_comb begin
      dec_sel   = ALUSEL_PASSB;
      dec_a     = '0;
      dec_b     = '0;
      dec_wen   = 1'b0;
      dec_legal = 1'b1;
      case (opcode)
         OP_R: begin
            dec_sel   = funct3_sel(f3, id_inst[30]);
            dec_a     = id_rs1_data;
            dec_b     = id_rs2_data;
            dec_wen   = 1'b1;
            dec_legal = (f7 == F7_BASE) || (f7 == F7_ALT);
         end
         OP_I: begin
            // addi has no subtract form, so inst[30] only matters for srli/srai.
            dec_sel = funct3_sel(f3, id_inst[30] && (f3 == 3'b101));
            dec_a   = id_rs1_data;
            dec_b   = (f3 == 3'b001 || f3 == 3'b101) ? shamt : imm_i;
            dec_wen = 1'b1;
         end
         OP_LUI: begin
            dec_b   = imm_u;
            dec_wen = 1'b1;
         end
         OP_AUIPC: begin
            dec_sel = ALUSEL_ADD;
            dec_a   = id_pc;
            dec_b   = imm_u;
            dec_wen = 1'b1;
         end
         OP_LOAD, OP_JALR: begin
            dec_sel = ALUSEL_ADD;
            dec_a   = id_rs1_data;
            dec_b   = imm_i;
            dec_wen = 1'b1;
         end
         OP_STORE: begin
            dec_sel = ALUSEL_ADD;
            dec_a   = id_rs1_data;
            dec_b   = imm_s;
         end
         OP_BRANCH: begin
            dec_sel = ALUSEL_ADD;
            dec_a   = id_pc;
            dec_b   = imm_b;
         end
         OP_JAL: begin
            dec_sel = ALUSEL_ADD;
            dec_a   = id_pc;
            dec_b   = imm_j;
            dec_wen = 1'b1;
         end
         default: dec_legal = 1'b0;
      endcase
      // x0 is hardwired zero, never write it back.
      if (rd == 5'd0) dec_wen = 1'b0;
   end

   // Value the register takes on an unstalled edge: decoded op, trap marker or bubble.
   always_comb begin
      ld_valid = 1'b0;
      ld_sel   = ALUSEL_PASSB;
      ld_a     = '0;
      ld_b     = '0;
      ld_rd    = '0;
      ld_wen   = 1'b0;
      ld_pc    = RESET_PC;
      ld_ill   = 1'b0;
      if (id_valid && dec_legal) begin
         ld_valid = 1'b1;
         ld_sel   = dec_sel;
         ld_a     = dec_a;
         ld_b     = dec_b;
         ld_rd    = rd;
         ld_wen   = dec_wen;
         ld_pc    = id_pc;
      end
`ifdef ID_ILLEGAL_TRAP_EN
      else if (id_valid) begin
         // Carried forward as a marked no-op so a later stage can raise the trap.
         ld_valid = 1'b1;
         ld_rd    = rd;
         ld_pc    = id_pc;
         ld_ill   = 1'b1;
      end
`endif
   end

   // ID/EX pipeline register: reset/flush bubble, stall hold, otherwise load.
   always_ff @(posedge clock) begin
      if (reset || flush) begin
         ex_valid   <= 1'b0;
         ex_alusel  <= ALUSEL_PASSB;
         ex_alu1    <= '0;
         ex_alu2    <= '0;
         ex_rd      <= '0;
         ex_reg_wen <= 1'b0;
         ex_pc      <= RESET_PC;
         ex_illegal <= 1'b0;
      end else if (!stall) begin
         ex_valid   <= ld_valid;
         ex_alusel  <= ld_sel;
         ex_alu1    <= ld_a;
         ex_alu2    <= ld_b;
         ex_rd      <= ld_rd;
         ex_reg_wen <= ld_wen;
         ex_pc      <= ld_pc;
         ex_illegal <= ld_ill;
      end
   end

endmodule
